// File: rtl/vmsu_wb_ctrl.sv
// Wishbone slave front-end for the 8-bit Vedic signed/unsigned multiplier.
// Holds operands and mode, sequences a fixed-latency run and captures the product.
module vmsu_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic        mul_signed,
    input  logic [15:0] mul_p,
    output logic        irq
);

    localparam logic [3:0] LAT = 4'(MUL_LATENCY);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_ack;
    logic [31:0] r_dat;
    logic [7:0]  r_opA;
    logic [7:0]  r_opB;
    logic        r_signed;
    logic        r_irqEn;
    logic        r_done;
    logic [15:0] r_result;
    logic        r_irq;

    logic        w_match;
    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_ctrlWr;
    logic        w_opWr;
    logic        w_statWr;
    logic        w_start;
    logic        w_capture;
    logic [31:0] w_rdata;
    logic        w_unused;

    // A request is only sampled while ack is low, which forces the 1,0,1,0 ack pattern.
    assign w_match   = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_req     = wbs_stb_i & wbs_cyc_i & w_match & ~r_ack;
    assign w_wr      = w_req & wbs_we_i;
    assign w_rd      = w_req & ~wbs_we_i;
    assign w_busy    = (r_state == ST_RUN);
    assign w_ctrlWr  = w_wr & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0];
    assign w_opWr    = w_wr & (wbs_adr_i[3:2] == 2'd1) & ~w_busy;
    assign w_statWr  = w_wr & (wbs_adr_i[3:2] == 2'd3) & wbs_sel_i[0];
    assign w_start   = w_ctrlWr & wbs_dat_i[0] & ~w_busy;
    assign w_capture = w_busy & (r_cnt == 4'd0);
    assign w_unused  = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next = ST_RUN;
            ST_RUN:  if (r_cnt == 4'd0) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (wbs_adr_i[3:2])
            2'd0: w_rdata = {29'd0, r_irqEn, r_signed, 1'b0};
            2'd1: w_rdata = {16'd0, r_opB, r_opA};
            2'd2: w_rdata = {(r_signed ? {16{r_result[15]}} : 16'd0), r_result};
            2'd3: w_rdata = {30'd0, r_done, w_busy};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_signed <= 1'b0;
            r_irqEn  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : '0;
            r_irq <= r_done & r_irqEn;
            if (w_ctrlWr) begin
                r_irqEn <= wbs_dat_i[2];
                if (!w_busy) r_signed <= wbs_dat_i[1];
            end
            if (w_opWr && wbs_sel_i[0]) r_opA <= wbs_dat_i[7:0];
            if (w_opWr && wbs_sel_i[1]) r_opB <= wbs_dat_i[15:8];
            if (w_start) begin
                r_cnt <= LAT;
            end else if (w_busy && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Capture beats a same-cycle W1C so a fresh result is never lost.
            if (w_capture) begin
                r_result <= mul_p;
                r_done   <= 1'b1;
            end else if (w_start || (w_statWr && wbs_dat_i[1])) begin
                r_done <= 1'b0;
            end
        end
    end

    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat;
    assign mul_a      = r_opA;
    assign mul_b      = r_opB;
    assign mul_signed = r_signed;
    assign irq        = r_irq;

endmodule
